uart_boot_loader: RTL and testbench

//  Consumes the received-byte AXI-Stream output of the uart block and loads a

---
 rtl/uart_boot_loader_pkg.sv | 17 +
 rtl/uart_boot_loader.sv | 201 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and protocol constants for the UART boot loader.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    CHECK = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC = 8'h55;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

endpackage

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses SYNC/ADDR/COUNT/DATA/CHK frames from the uart
// receive stream, writes little-endian words to memory and answers ACK/NAK.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_tdata,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  output logic [7:0]            tx_tdata,
  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t                state_q, state_d;
  logic [31:0]           addr_sh_q, addr_sh_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           words_q, words_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic [7:0]            chk_q, chk_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [7:0]            tx_tdata_q, tx_tdata_d;
  logic                  tx_tvalid_q, tx_tvalid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [31:0]           word_next;
  logic [15:0]           words_next;

  assign rx_tready  = (state_q != RESP);
  assign accept     = rx_tvalid && rx_tready;
  assign word_next  = {rx_tdata, word_q[31:8]};
  assign words_next = {rx_tdata, words_q[15:8]};

  assign tx_tdata  = tx_tdata_q;
  assign tx_tvalid = tx_tvalid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign done      = done_q;
  assign error     = error_q;

  // Frame parser: next state, field assembly, write strobe, response and timeout.
  always_comb begin
    state_d     = state_q;
    addr_sh_d   = addr_sh_q;
    wr_addr_d   = wr_addr_q;
    words_d     = words_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    chk_d       = chk_q;
    tmo_d       = '0;
    tx_tdata_d  = tx_tdata_q;
    tx_tvalid_d = tx_tvalid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    done_d      = done_q;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        if (accept && rx_tdata == SYNC) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          byte_cnt_d = '0;
          chk_d      = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (accept) begin
          addr_sh_d  = {rx_tdata, addr_sh_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Bits above ADDR_WIDTH are dropped here so all later address
            // arithmetic wraps naturally in the narrower register.
            wr_addr_d  = ADDR_WIDTH'({rx_tdata, addr_sh_q[31:8]});
            byte_cnt_d = '0;
            state_d    = COUNT;
          end
        end
      end
      COUNT: begin
        if (accept) begin
          words_d    = words_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd1) begin
            byte_cnt_d = '0;
            word_idx_d = '0;
            state_d    = (words_next == 16'd0) ? CHECK : DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d     = word_next;
          chk_d      = chk_q ^ rx_tdata;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr_q;
            mem_wdata_d = word_next;
            wr_addr_d   = wr_addr_q + ADDR_WIDTH'(4);
            word_idx_d  = word_idx_q + 16'd1;
            if (word_idx_q == words_q - 16'd1) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          tx_tvalid_d = 1'b1;
          if (rx_tdata == chk_q) begin
            tx_tdata_d = ACK;
            done_d     = 1'b1;
          end else begin
            tx_tdata_d = NAK;
            error_d    = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (tx_tready) begin
          tx_tvalid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte timeout applies only while a frame is being received.
    if (state_q inside {ADDR, COUNT, DATA, CHECK} && !accept) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        error_d = 1'b1;
        done_d  = 1'b0;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_sh_q   <= '0;
      wr_addr_q   <= '0;
      words_q     <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      tx_tdata_q  <= '0;
      tx_tvalid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_sh_q   <= addr_sh_d;
      wr_addr_q   <= wr_addr_d;
      words_q     <= words_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      tx_tdata_q  <= tx_tdata_d;
      tx_tvalid_q <= tx_tvalid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed testbench for uart_boot_loader.
module tb_uart_boot_loader;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_tdata;
  logic          rx_tvalid;
  logic          rx_tready;
  logic [7:0]    tx_tdata;
  logic          tx_tvalid;
  logic          tx_tready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          done;
  logic          error;

  int tests = 0;
  int fails = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          tx_cnt = 0;
  logic [7:0]  tx_last = '0;
  logic [7:0]  frame[$];

  uart_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_tdata  (rx_tdata),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Record memory writes and response handshakes once per cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end
      if (tx_tvalid && tx_tready) begin
        tx_cnt  = tx_cnt + 1;
        tx_last = tx_tdata;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_tvalid = 1'b1;
    rx_tdata  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_tready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_byte: byte %02h not accepted within 50 cycles (rx_tready=%0b, need 1)", b, rx_tready);
    end
  endtask

  // Sends every byte of 'frame' back to back, then idles the stream.
  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
    rx_tvalid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    tx_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_tvalid = 1'b0; rx_tdata = '0; tx_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({rx_tready, tx_tvalid, tx_tdata, mem_we, mem_addr, mem_wdata, done, error} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b tv=%0b td=%02h we=%0b a=%08h d=%08h done=%0b err=%0b, need 1 0 00 0 0 0 0 0",
               rx_tready, tx_tvalid, tx_tdata, mem_we, mem_addr, mem_wdata, done, error);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    clear_log();
    // XOR of the eight data bytes is 0x44.
    frame = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    send_frame();
    settle();
    tests++;
    if (wa.size() !== 2) begin
      fails++;
      $display("FAIL good_wr_count: got %0d writes, need 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h44332211) begin
        fails++;
        $display("FAIL good_wr0: got (%08h,%08h), need (00000000,44332211)", wa[0], wd[0]);
      end
      tests++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'hDDCCBBAA) begin
        fails++;
        $display("FAIL good_wr1: got (%08h,%08h), need (00000004,ddccbbaa)", wa[1], wd[1]);
      end
    end
    tests++;
    if (tx_cnt !== 1 || tx_last !== 8'h06) begin
      fails++;
      $display("FAIL good_tx: got %0d responses last %02h, need 1 response 06", tx_cnt, tx_last);
    end
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL good_flags: got done=%0b error=%0b, need 1 0", done, error);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    frame = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h45};
    send_frame();
    settle();
    tests++;
    if (wa.size() !== 2) begin
      fails++;
      $display("FAIL bad_wr_count: got %0d writes, need 2", wa.size());
    end
    tests++;
    if (tx_cnt !== 1 || tx_last !== 8'h15) begin
      fails++;
      $display("FAIL bad_tx: got %0d responses last %02h, need 1 response 15", tx_cnt, tx_last);
    end
    tests++;
    if (done !== 1'b0 || error !== 1'b1) begin
      fails++;
      $display("FAIL bad_flags: got done=%0b error=%0b, need 0 1", done, error);
    end
  endtask

  task automatic test_garbage_empty();
    clear_log();
    frame = '{8'h00, 8'hFF, 8'h13, 8'h55, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    settle();
    tests++;
    if (wa.size() !== 0) begin
      fails++;
      $display("FAIL empty_wr_count: got %0d writes, need 0", wa.size());
    end
    tests++;
    if (tx_cnt !== 1 || tx_last !== 8'h06 || done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL empty_resp: got %0d resp %02h done=%0b err=%0b, need 1 06 1 0", tx_cnt, tx_last, done, error);
    end
  endtask

  task automatic test_timeout();
    clear_log();
    frame = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02};
    send_frame();
    repeat (2 * TMO) @(posedge clk);
    #1;
    tests++;
    if (error !== 1'b1 || done !== 1'b0 || tx_cnt !== 0 || wa.size() !== 0 || rx_tready !== 1'b1) begin
      fails++;
      $display("FAIL timeout: got err=%0b done=%0b tx=%0d wr=%0d rdy=%0b, need 1 0 0 0 1",
               error, done, tx_cnt, wa.size(), rx_tready);
    end
    frame = '{8'h55, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame();
    settle();
    tests++;
    if (wa.size() !== 1 || wa[0] !== 32'h200 || wd[0] !== 32'h04030201) begin
      fails++;
      $display("FAIL after_timeout_wr: got %0d writes first (%08h,%08h), need 1 (00000200,04030201)",
               wa.size(), (wa.size() > 0) ? wa[0] : 32'hx, (wd.size() > 0) ? wd[0] : 32'hx);
    end
    tests++;
    if (tx_cnt !== 1 || tx_last !== 8'h06 || done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL after_timeout_resp: got %0d resp %02h done=%0b err=%0b, need 1 06 1 0", tx_cnt, tx_last, done, error);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    frame = '{8'h55, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
              8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    send_frame();
    settle();
    tests++;
    if (wa.size() !== 2) begin
      fails++;
      $display("FAIL wrap_wr_count: got %0d writes, need 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 32'hFFFFFFFC || wd[0] !== 32'h1 || wa[1] !== 32'h0 || wd[1] !== 32'h2) begin
        fails++;
        $display("FAIL wrap_addr: got (%08h,%08h),(%08h,%08h), need (fffffffc,00000001),(00000000,00000002)",
                 wa[0], wd[0], wa[1], wd[1]);
      end
    end
    tests++;
    if (tx_cnt !== 1 || tx_last !== 8'h06) begin
      fails++;
      $display("FAIL wrap_tx: got %0d responses last %02h, need 1 response 06", tx_cnt, tx_last);
    end
  endtask

  task automatic test_tx_stall_and_reset();
    bit seen = 0;
    clear_log();
    tx_tready = 1'b0;
    frame = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    for (int i = 0; i < 10; i++) begin
      if (tx_tvalid) begin seen = 1; break; end
      @(posedge clk);
      #1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL stall_tvalid: tx_tvalid=%0b after 10 cycles, need 1", tx_tvalid);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h06 || rx_tready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got tv=%0b td=%02h rdy=%0b, need 1 06 0", i, tx_tvalid, tx_tdata, rx_tready);
      end
      @(posedge clk);
      #1;
    end
    tx_tready = 1'b1;
    settle();
    tests++;
    if (tx_cnt !== 1 || tx_tvalid !== 1'b0 || rx_tready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: got tx=%0d tv=%0b rdy=%0b, need 1 0 1", tx_cnt, tx_tvalid, rx_tready);
    end
    // Leave the loader mid-DATA with non-zero mem_addr/tx_tdata from earlier frames.
    frame = '{8'h55, 8'h00, 8'h03, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEE, 8'hFF};
    send_frame();
    tests++;
    if (mem_addr !== 32'h300) begin
      fails++;
      $display("FAIL pre_reset_addr: got %08h, need 00000300", mem_addr);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({rx_tready, tx_tvalid, tx_tdata, mem_we, mem_addr, mem_wdata, done, error} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: rdy=%0b tv=%0b td=%02h we=%0b a=%08h d=%08h done=%0b err=%0b, need 1 0 00 0 0 0 0 0",
               rx_tready, tx_tvalid, tx_tdata, mem_we, mem_addr, mem_wdata, done, error);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage_empty();
    test_timeout();
    test_wrap();
    test_tx_stall_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
